// File: rtl/vga_scan_pkg.sv
// Shared VGA timing defaults, widths and types for the raster generator and colour lookup.
package vga_scan_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned POS_X_W = 10;
    localparam int unsigned POS_Y_W = 9;
    localparam int unsigned COLOR_W = 16;

    // 640x480@60 Hz with a 100 MHz system clock
    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_COLOR_LAT = 2;
    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    function automatic logic in_window(logic [CNT_W-1:0] val, logic [CNT_W-1:0] lo,
                                       logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_if.sv
// Raster-side bundle: scan coordinates out to the colour lookup, colour back, VGA pins out.
interface vga_scan_if;
    import vga_scan_pkg::*;

    logic [POS_X_W-1:0] posX;
    logic [POS_Y_W-1:0] posY;
    logic [COLOR_W-1:0] icolor;
    logic               pix_tick;
    logic               frame_start;
    logic [3:0]         r;
    logic [3:0]         g;
    logic [3:0]         b;
    logic               hs;
    logic               vs;

    modport master (
        output posX, posY, pix_tick, frame_start, r, g, b, hs, vs,
        input  icolor
    );

    modport slave (
        input  posX, posY, pix_tick, frame_start, r, g, b, hs, vs,
        output icolor
    );

endinterface

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: pulses pix_tick in the last system clock of every pixel period.
module vga_pix_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q;
    logic [DivW-1:0] div_d;

    always_comb begin
        div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_tick = (div_q == DivLast);

endmodule

// File: rtl/vga_scan.sv
// VGA raster generator: h/v counters, scan coordinates for the colour lookup,
// and registered rgb/hs/vs that all show the pixel of the previous pixel period.
module vga_scan
    import vga_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned COLOR_LAT = DEF_COLOR_LAT,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP
) (
    input logic        clk,
    input logic        rst_n,
    vga_scan_if.master bus
);

    localparam logic [CNT_W-1:0] HActive = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HsStart = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HsEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VActive = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VLast   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VsStart = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VsEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_scan: CLK_DIV must be at least 2");
    end
    if (COLOR_LAT + 1 > CLK_DIV) begin : g_bad_lat
        $error("vga_scan: COLOR_LAT must not exceed CLK_DIV-1");
    end

    logic                tick;
    logic [CNT_W-1:0]    h_q, h_d;
    logic [CNT_W-1:0]    v_q, v_d;
    logic                h_wrap, v_wrap;
    logic                active;
    logic                hs_d, vs_d;
    logic [POS_X_W-1:0]  pos_x_q, pos_x_d;
    logic [POS_Y_W-1:0]  pos_y_q, pos_y_d;
    rgb_t                rgb_q, rgb_d;
    logic                hs_q, vs_q;
    logic                frame_start_q;
    logic                unused_icolor;

    vga_pix_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_tick(tick)
    );

    assign unused_icolor = ^bus.icolor[COLOR_W-1:12];

    always_comb begin
        h_wrap = (h_q == HLast);
        v_wrap = (v_q == VLast);
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + 1'b1;
        end
        pos_x_d = (h_d < HActive) ? h_d : '0;
        pos_y_d = (v_d < VActive) ? v_d[POS_Y_W-1:0] : '0;

        // Decoded from the current pixel; the output register supplies the one-pixel delay
        // that lines rgb and syncs up with the pixel whose colour arrives now.
        active = (h_q < HActive) && (v_q < VActive);
        hs_d   = ~in_window(h_q, HsStart, HsEnd);
        vs_d   = ~in_window(v_q, VsStart, VsEnd);
        rgb_d  = active ? rgb_t'(bus.icolor[11:0]) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= tick & h_wrap & v_wrap;
            if (tick) begin
                h_q     <= h_d;
                v_q     <= v_d;
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
                rgb_q   <= rgb_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
            end
        end
    end

    assign bus.pix_tick    = tick;
    assign bus.frame_start = frame_start_q;
    assign bus.posX        = pos_x_q;
    assign bus.posY        = pos_y_q;
    assign bus.r           = rgb_q.r;
    assign bus.g           = rgb_q.g;
    assign bus.b           = rgb_q.b;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;

endmodule
